// File: rtl/fir_sym_decim_if.sv
// Sample/coefficient handshake bundle for fir_sym_decim.
// The master drives samples and coefficient writes; the slave is the filter.
interface fir_sym_decim_if #(
  parameter int unsigned W  = 20,
  parameter int unsigned WC = 18
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_input;
  logic          coef_we;
  logic [5:0]    coef_addr;
  logic [WC-1:0] coef_data;
  logic          out_valid;
  logic [W-1:0]  data_output;
  logic          sat;
  logic          coef_err;

  modport master (
    output in_valid, data_input, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, data_output, sat, coef_err
  );

  modport slave (
    input  in_valid, data_input, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, data_output, sat, coef_err
  );
endinterface

// File: rtl/fir_sym_decim.sv
// Symmetric linear-phase FIR decimator: one shared pre-add/multiply/accumulate
// path walks the N/2 coefficient pairs per output, with run-time coefficient writes.
module fir_sym_decim #(
  parameter int unsigned W  = 20,
  parameter int unsigned WC = 18,
  parameter int unsigned N  = 24,
  parameter int unsigned R  = 1
) (
  input logic            clk,
  input logic            reset_b,
  fir_sym_decim_if.slave bus
);

  localparam int unsigned Half = N / 2;
  localparam int unsigned KW   = (Half > 1) ? $clog2(Half) : 1;
  localparam int unsigned XW   = $clog2(N);
  localparam int unsigned DW   = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned PW   = W + WC + 1;
  localparam int unsigned WA   = PW + $clog2(Half);

  localparam logic signed [WA:0] RndHalf = {{(WA + 1 - WC){1'b0}}, 1'b1, {(WC - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StDrain, StRound} state_e;

  state_e                state_q, state_d;
  logic                  rdy_q;
  logic [DW-1:0]         dec_q, dec_d;
  logic [KW-1:0]         k_q, k_d;
  logic [1:0]            drn_q, drn_d;
  logic signed [W-1:0]   x_q [N];
  logic signed [W-1:0]   x_d [N];
  logic signed [WC-1:0]  coef_q [Half];
  logic signed [WC-1:0]  coef_d [Half];
  logic signed [W:0]     pre_q, pre_d;
  logic signed [WC-1:0]  cpipe_q, cpipe_d;
  logic                  pre_vld_q, pre_vld_d;
  logic signed [PW-1:0]  prod_q, prod_d;
  logic                  prod_vld_q;
  logic signed [WA-1:0]  acc_q, acc_d;
  logic [W-1:0]          y_q, y_d;
  logic                  sat_q, sat_d;
  logic                  err_q, err_d;

  logic                  in_ready;
  logic                  accept;
  logic                  dec_last;
  logic                  addr_ok;
  logic [XW-1:0]         k_idx;
  logic [XW-1:0]         m_idx;
  logic signed [WA:0]    rnd_sum;
  logic signed [WA:0]    rnd_sh;
  logic                  ovf;
  logic [W-1:0]          y_rnd;

  assign in_ready = rdy_q && (state_q == StIdle);
  assign accept   = bus.in_valid && in_ready;
  assign dec_last = (dec_q == DW'(R - 1));
  assign addr_ok  = (32'(bus.coef_addr) < Half);
  assign k_idx    = XW'(k_q);
  assign m_idx    = XW'(N - 1) - XW'(k_q);

  // Round half up, then clip when the bits above the output sign disagree.
  always_comb begin
    rnd_sum = (WA + 1)'(acc_q) + RndHalf;
    rnd_sh  = rnd_sum >>> WC;
    ovf     = (|rnd_sh[WA:W-1]) && !(&rnd_sh[WA:W-1]);
    if (ovf) begin
      y_rnd = rnd_sh[WA] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
    end else begin
      y_rnd = rnd_sh[W-1:0];
    end
  end

  // Datapath stages run every cycle; only the valid bits gate accumulation.
  always_comb begin
    pre_d   = (W + 1)'(x_q[k_idx]) + (W + 1)'(x_q[m_idx]);
    cpipe_d = coef_q[k_q];
    prod_d  = PW'(pre_q) * PW'(cpipe_q);
  end

  always_comb begin
    state_d   = state_q;
    dec_d     = dec_q;
    k_d       = k_q;
    drn_d     = drn_q;
    x_d       = x_q;
    coef_d    = coef_q;
    acc_d     = acc_q;
    y_d       = y_q;
    sat_d     = sat_q;
    err_d     = err_q;
    pre_vld_d = 1'b0;

    // A write that coincides with the starting accept lands before the first MAC read.
    if (bus.coef_we) begin
      if ((state_q == StIdle) && addr_ok) begin
        coef_d[bus.coef_addr[KW-1:0]] = bus.coef_data;
      end else begin
        err_d = 1'b1;
      end
    end

    if (prod_vld_q) begin
      acc_d = acc_q + WA'(prod_q);
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          x_d[0] = bus.data_input;
          for (int i = 1; i < N; i++) begin
            x_d[i] = x_q[i-1];
          end
          if (dec_last) begin
            dec_d   = '0;
            acc_d   = '0;
            k_d     = '0;
            state_d = StMac;
          end else begin
            dec_d = dec_q + 1'b1;
          end
        end
      end
      StMac: begin
        pre_vld_d = 1'b1;
        k_d       = k_q + 1'b1;
        if (k_q == KW'(Half - 1)) begin
          drn_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Pre-add, product and accumulate stages flush; the last cycle rounds.
        drn_d = drn_q + 1'b1;
        if (drn_q == 2'd2) begin
          y_d     = y_rnd;
          sat_d   = ovf;
          state_d = StRound;
        end
      end
      StRound: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      rdy_q      <= 1'b0;
      dec_q      <= '0;
      k_q        <= '0;
      drn_q      <= '0;
      x_q        <= '{default: '0};
      coef_q     <= '{default: '0};
      pre_q      <= '0;
      cpipe_q    <= '0;
      pre_vld_q  <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      y_q        <= '0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      dec_q      <= dec_d;
      k_q        <= k_d;
      drn_q      <= drn_d;
      x_q        <= x_d;
      coef_q     <= coef_d;
      pre_q      <= pre_d;
      cpipe_q    <= cpipe_d;
      pre_vld_q  <= pre_vld_d;
      prod_q     <= prod_d;
      prod_vld_q <= pre_vld_q;
      acc_q      <= acc_d;
      y_q        <= y_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == StRound);
  assign bus.data_output = y_q;
  assign bus.sat         = sat_q;
  assign bus.coef_err    = err_q;

endmodule

// File: tb/tb_fir_sym_decim.sv
// Bench for fir_sym_decim: R=1 and R=4 instances, table-driven constant-input vectors,
// a behavioural model feeding an expected-output queue, and hand sequences for corners.
module tb_fir_sym_decim;

  localparam int W  = 20;
  localparam int WC = 18;
  localparam int N  = 24;
  localparam int H  = N / 2;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  fir_sym_decim_if #(.W(W), .WC(WC)) bus1 ();
  fir_sym_decim_if #(.W(W), .WC(WC)) bus4 ();

  fir_sym_decim #(.W(W), .WC(WC), .N(N), .R(1)) dut1 (
    .clk    (clk),
    .reset_b(reset_b),
    .bus    (bus1)
  );

  fir_sym_decim #(.W(W), .WC(WC), .N(N), .R(4)) dut4 (
    .clk    (clk),
    .reset_b(reset_b),
    .bus    (bus4)
  );

  typedef struct {
    int y;
    bit sat;
  } exp_t;

  typedef struct {
    string name;
    int    c10;
    int    c11;
    int    din;
    int    y;
    bit    sat;
  } vec_t;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   mdl_x[N];
  int   mdl_c[H];
  int   rd = 0;
  vec_t vecs[7];

  // Output capture for the R=1 instance; only this block writes these.
  int got_y[1024];
  bit got_sat[1024];
  int out_n = 0;

  always @(negedge clk) begin
    if (bus1.out_valid && out_n < 1024) begin
      got_y[out_n]   <= int'($signed(bus1.data_output));
      got_sat[out_n] <= bus1.sat;
      out_n          <= out_n + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  function automatic void chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  function automatic void model_push();
    longint acc;
    longint r;
    exp_t   e;
    acc = 0;
    for (int k = 0; k < H; k++) begin
      acc += longint'(mdl_c[k]) * longint'(mdl_x[k] + mdl_x[N-1-k]);
    end
    r = (acc + 131072) >>> 18;
    e.sat = (r > 524287) || (r < -524288);
    if (r > 524287) e.y = 524287;
    else if (r < -524288) e.y = -524288;
    else e.y = int'(r);
    exp_q.push_back(e);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_b = 1'b0;
    bus1.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
    bus1.coef_we  = 1'b0;
    bus4.coef_we  = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus1.in_ready, 0);
    chk("rst_ready4", bus4.in_ready, 0);
    chk("rst_valid", bus1.out_valid, 0);
    chk("rst_dout", bus1.data_output, 0);
    chk("rst_sat", bus1.sat, 0);
    chk("rst_err", bus1.coef_err, 0);
    reset_b = 1'b1;
    #1;
    chk("rel_ready_low", bus1.in_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_ready_high", bus1.in_ready, 1);
    chk("rel_ready_high4", bus4.in_ready, 1);
    for (int i = 0; i < N; i++) mdl_x[i] = 0;
    for (int i = 0; i < H; i++) mdl_c[i] = 0;
    exp_q.delete();
    rd = out_n;
  endtask

  // Coefficient writes go to both instances; the model tracks only accepted ones.
  task automatic wcoef(input int a, input int d, input bit upd);
    @(negedge clk);
    bus1.coef_we = 1'b1;
    bus1.coef_addr = 6'(a);
    bus1.coef_data = 18'(d);
    bus4.coef_we = 1'b1;
    bus4.coef_addr = 6'(a);
    bus4.coef_data = 18'(d);
    if (upd) mdl_c[a] = d;
    @(posedge clk);
    #1;
    bus1.coef_we = 1'b0;
    bus4.coef_we = 1'b0;
  endtask

  task automatic send(input int v, input bit we = 1'b0, input int wa = 0, input int wd = 0);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus1.in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      chk("ready_timeout", bus1.in_ready, 1);
      return;
    end
    bus1.in_valid = 1'b1;
    bus1.data_input = 20'(v);
    bus1.coef_we = we;
    bus1.coef_addr = 6'(wa);
    bus1.coef_data = 18'(wd);
    if (we && wa < H) mdl_c[wa] = wd;
    for (int i = N - 1; i > 0; i--) mdl_x[i] = mdl_x[i-1];
    mdl_x[0] = v;
    model_push();
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus1.coef_we = 1'b0;
  endtask

  task automatic drain();
    int   guard;
    exp_t e;
    guard = 0;
    while (out_n < rd + exp_q.size() && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    chk("out_count", out_n, rd + exp_q.size());
    while (exp_q.size() > 0 && rd < out_n) begin
      e = exp_q.pop_front();
      chk("model_y", got_y[rd], e.y);
      chk("model_sat", got_sat[rd], e.sat);
      rd++;
    end
    exp_q.delete();
    rd = out_n;
    repeat (20) @(posedge clk);
    chk("no_extra_out", out_n, rd);
  endtask

  task automatic load_dc();
    wcoef(10, 65536, 1'b1);
    wcoef(11, 65536, 1'b1);
  endtask

  task automatic run_r4();
    int r4_exp[6];
    int acc_n;
    int trig;
    int low_run;
    int outs;
    r4_exp = '{0, 0, 250, 500, 500, 500};
    acc_n = 0;
    trig = 0;
    low_run = 0;
    outs = 0;
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.data_input = 20'(500);
    for (int cyc = 0; cyc < 300 && outs < 6; cyc++) begin
      if (bus4.out_valid) begin
        chk("r4_latency", cyc - trig, 16);
        chk("r4_y", int'($signed(bus4.data_output)), r4_exp[outs]);
        outs++;
      end
      if (!bus4.in_ready) begin
        low_run++;
      end else begin
        if (low_run > 0) chk("r4_ready_low", low_run, 16);
        low_run = 0;
        acc_n++;
        if (acc_n % 4 == 0) trig = cyc;
      end
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    chk("r4_outputs", outs, 6);
  endtask

  initial begin
    int base;
    bus1.in_valid = 1'b0;
    bus1.data_input = '0;
    bus1.coef_we = 1'b0;
    bus1.coef_addr = '0;
    bus1.coef_data = '0;
    bus4.in_valid = 1'b0;
    bus4.data_input = '0;
    bus4.coef_we = 1'b0;
    bus4.coef_addr = '0;
    bus4.coef_data = '0;

    // Unity gain is split over two taps so every coefficient fits in WC signed bits.
    vecs[0] = '{"dc_gain", 65536, 65536, 1000, 1000, 1'b0};
    vecs[1] = '{"dc_neg", 65536, 65536, -777, -777, 1'b0};
    vecs[2] = '{"round_a", 0, 1, 131072, 1, 1'b0};
    vecs[3] = '{"round_b", 0, 1, 65536, 1, 1'b0};
    vecs[4] = '{"round_c", 0, 1, -65536, 0, 1'b0};
    vecs[5] = '{"sat_pos", 131071, 131071, 524287, 524287, 1'b1};
    vecs[6] = '{"sat_neg", 131071, 131071, -524288, -524288, 1'b1};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      wcoef(10, vecs[i].c10, 1'b1);
      wcoef(11, vecs[i].c11, 1'b1);
      repeat (16) send(vecs[i].din);
      drain();
      chk({vecs[i].name, "_y"}, got_y[out_n-1], vecs[i].y);
      chk({vecs[i].name, "_sat"}, got_sat[out_n-1], vecs[i].sat);
    end

    // Impulse of 32 against coef[k]=(k+1)*8192 gives the tap ramp 1..12,12..1.
    do_reset();
    for (int k = 0; k < H; k++) wcoef(k, (k + 1) * 8192, 1'b1);
    base = out_n;
    send(32);
    repeat (24) send(0);
    drain();
    for (int j = 0; j < 25; j++) begin
      chk("impulse", got_y[base+j], (j < 12) ? j + 1 : ((j < 24) ? 24 - j : 0));
    end

    // Write coinciding with the starting accept is used by that computation.
    do_reset();
    load_dc();
    repeat (16) send(700);
    drain();
    send(700, 1'b1, 11, 0);
    drain();
    chk("coef_with_start", got_y[out_n-1], 350);

    // Write during MAC is dropped and flagged.
    do_reset();
    load_dc();
    repeat (16) send(1000);
    repeat (3) @(negedge clk);
    wcoef(11, 0, 1'b0);
    chk("err_mac", bus1.coef_err, 1);
    drain();
    repeat (2) send(1000);
    drain();
    chk("coef_kept_mac", got_y[out_n-1], 1000);

    do_reset();
    wcoef(12, 7, 1'b0);
    chk("err_addr12", bus1.coef_err, 1);
    do_reset();
    load_dc();
    wcoef(43, 0, 1'b0);
    chk("err_addr43", bus1.coef_err, 1);
    repeat (16) send(1000);
    drain();
    chk("coef_kept_43", got_y[out_n-1], 1000);

    // Reset mid-MAC aborts the computation.
    do_reset();
    load_dc();
    repeat (16) send(1000);
    drain();
    send(1000);
    repeat (4) @(negedge clk);
    do_reset();
    repeat (30) @(posedge clk);
    chk("abort_no_out", out_n, rd);
    chk("abort_dout", bus1.data_output, 0);

    do_reset();
    load_dc();
    run_r4();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
